// File: rtl/input_conditioner_pkg.sv
// Shared constants for the pin-side input conditioner.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package input_conditioner_pkg;

    // Board population
    localparam int NUM_SWITCHES = 10;
    localparam int NUM_BUTTONS  = 4;

    // Levels presented while idle and after reset: switches off,
    // buttons released (pins are active-low).
    localparam logic SWITCH_IDLE = 1'b0;
    localparam logic BUTTON_IDLE = 1'b1;

    // 1 ms of stability at a 50 MHz core clock
    localparam int DEBOUNCE_CYCLES_50MHZ = 50000;

    // Two flops is the minimum for metastability settling
    localparam int SYNC_STAGES_DEFAULT = 2;

    // Counter width able to hold 0 .. cycles
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/input_conditioner_debounce_bit.sv
// One-bit synchroniser + debouncer with registered rise/fall pulses.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES edges from first sampling edge to level change.
// Backpressure: none; free-running, outputs are registered every cycle.
module debounce_bit
    import input_conditioner_pkg::*;
#(
    parameter int   SYNC_STAGES     = SYNC_STAGES_DEFAULT,
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
    parameter logic IDLE            = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Synchroniser chain; the newest sample enters at bit 0
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;

    // Debounce state
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             stable_q;
    logic             stable_d;

    // Edge pulses, registered on the same edge as the level change
    logic rise_q;
    logic rise_d;
    logic fall_q;
    logic fall_d;

    // Capture the asynchronous pin through the flop chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{IDLE}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // Count consecutive mismatching cycles; any matching cycle restarts the
    // count, and the last mismatching cycle accepts the new level together
    // with its edge pulse.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (sync == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d    = '0;
            stable_d = sync;
            rise_d   = sync;
            fall_d   = ~sync;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Debounce state and pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            stable_q <= IDLE;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign level = stable_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/input_conditioner.sv
// Synchronises and debounces board switches/buttons; emits clean levels and press/release pulses.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES edges per bit; pulses coincide with the level change.
// Backpressure: none; outputs are registered levels/pulses, consumer must sample every cycle.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_SWITCHES-1:0] switch_raw,
    input  logic [NUM_BUTTONS-1:0]  button_raw,
    output logic [NUM_SWITCHES-1:0] switch,
    output logic [NUM_BUTTONS-1:0]  button,
    output logic [NUM_BUTTONS-1:0]  button_press,
    output logic [NUM_BUTTONS-1:0]  button_release
);

    // Switch edges are not consumed downstream; these nets only terminate
    // the instance pins.
    logic [NUM_SWITCHES-1:0] switch_rise_unused;
    logic [NUM_SWITCHES-1:0] switch_fall_unused;

    // Slide switches: active-high, idle off
    for (genvar i = 0; i < NUM_SWITCHES; i++) begin : g_switch
        debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .IDLE            (SWITCH_IDLE)
        ) u_debounce (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (switch_raw[i]),
            .level (switch[i]),
            .rise  (switch_rise_unused[i]),
            .fall  (switch_fall_unused[i])
        );
    end

    // Push-buttons: active-low, so a press is a falling level and a
    // release is a rising level.
    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_button
        debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .IDLE            (BUTTON_IDLE)
        ) u_debounce (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (button_raw[i]),
            .level (button[i]),
            .rise  (button_release[i]),
            .fall  (button_press[i])
        );
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Randomised + directed bench for input_conditioner with a sliding-window reference model.
// Latency: checks levels every cycle and pulses against predicted edge numbers.
// Backpressure: n/a.
module tb_input_conditioner;
    import input_conditioner_pkg::*;

    localparam int D  = 4;
    localparam int S  = 2;
    localparam int W  = S + D;
    localparam int NB = NUM_SWITCHES + NUM_BUTTONS;
    localparam logic [NB-1:0] IDLE_ALL = {{NUM_BUTTONS{BUTTON_IDLE}}, {NUM_SWITCHES{SWITCH_IDLE}}};

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [NUM_SWITCHES-1:0] switch_raw = '1;
    logic [NUM_BUTTONS-1:0]  button_raw = '0;
    logic [NUM_SWITCHES-1:0] switch;
    logic [NUM_BUTTONS-1:0]  button;
    logic [NUM_BUTTONS-1:0]  button_press;
    logic [NUM_BUTTONS-1:0]  button_release;

    input_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .SYNC_STAGES     (S)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .switch_raw     (switch_raw),
        .button_raw     (button_raw),
        .switch         (switch),
        .button         (button),
        .button_press   (button_press),
        .button_release (button_release)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  press;
        logic [3:0]  rel;
    } ev_t;

    ev_t           exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int unsigned   cyc = 0;
    logic [W-1:0]  hist [NB];
    logic [NB-1:0] mdl_lvl;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a bit takes value v once the last D synchronised
    // samples (raw samples taken S..S+D-1 edges ago) all equal v.
    initial begin : model
        logic [NB-1:0] raw_all;
        logic [NB-1:0] new_lvl;
        logic [D-1:0]  win;
        ev_t           ev;
        for (int i = 0; i < NB; i++) hist[i] = {W{IDLE_ALL[i]}};
        mdl_lvl = IDLE_ALL;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < NB; i++) hist[i] = {W{IDLE_ALL[i]}};
                mdl_lvl = IDLE_ALL;
                exp_q.delete();
            end else begin
                cyc++;
                raw_all = {button_raw, switch_raw};
                new_lvl = mdl_lvl;
                for (int i = 0; i < NB; i++) begin
                    hist[i] = {hist[i][W-2:0], raw_all[i]};
                    win = hist[i][W-1:S];
                    if (&win) new_lvl[i] = 1'b1;
                    else if (~|win) new_lvl[i] = 1'b0;
                end
                ev.cyc   = cyc;
                ev.press = mdl_lvl[NB-1:NUM_SWITCHES] & ~new_lvl[NB-1:NUM_SWITCHES];
                ev.rel   = ~mdl_lvl[NB-1:NUM_SWITCHES] & new_lvl[NB-1:NUM_SWITCHES];
                if ((ev.press | ev.rel) != 4'h0) exp_q.push_back(ev);
                mdl_lvl = new_lvl;
            end
        end
    end

    // Monitor: levels every cycle, pulses against the scoreboard queue
    initial begin : monitor
        ev_t ev;
        forever begin
            @(negedge clk);
            chk("switch_level", 32'(switch), 32'(mdl_lvl[NUM_SWITCHES-1:0]));
            chk("button_level", 32'(button), 32'(mdl_lvl[NB-1:NUM_SWITCHES]));
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                ev = exp_q.pop_front();
                chk("press_pulse", 32'(button_press), 32'(ev.press));
                chk("release_pulse", 32'(button_release), 32'(ev.rel));
            end else begin
                chk("no_pulse", 32'({button_press, button_release}), 32'h0);
            end
        end
    end

    // Advance n edges, leaving time 2 units after the last edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Count edges until (button & mask) === val; capture pulses at that edge
    task automatic wait_btn(input logic [3:0] mask, input logic [3:0] val,
                            output int n, output logic [3:0] pr, output logic [3:0] rl);
        n  = -1;
        pr = 'x;
        rl = 'x;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if ((button & mask) === val) begin
                n  = k;
                pr = button_press;
                rl = button_release;
                break;
            end
        end
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_switch"}, 32'(switch), 32'h000);
        chk({tag, "_button"}, 32'(button), 32'hF);
        chk({tag, "_press"}, 32'(button_press), 32'h0);
        chk({tag, "_release"}, 32'(button_release), 32'h0);
    endtask

    initial begin : stim
        int         n;
        logic [3:0] pr;
        logic [3:0] rl;

        // Reset held with all inputs opposite to idle
        for (int k = 0; k < 5; k++) begin
            step(1);
            chk_reset_outputs("reset");
        end
        switch_raw = '0;
        button_raw = '1;
        step(1);
        rst_n = 1'b1;
        step(10);

        // Clean press and release of button 1
        button_raw[1] = 1'b0;
        wait_btn(4'b0010, 4'b0000, n, pr, rl);
        chk("press_latency", 32'(n), 32'd6);
        chk("press_vector", 32'(pr), 32'b0010);
        chk("press_no_release", 32'(rl), 32'h0);
        step(4);
        button_raw[1] = 1'b1;
        wait_btn(4'b0010, 4'b0010, n, pr, rl);
        chk("release_latency", 32'(n), 32'd6);
        chk("release_vector", 32'(rl), 32'b0010);
        step(6);

        // Bounce on button 2, then held pressed
        for (int k = 0; k < 4; k++) begin
            button_raw[2] = k[0];
            step(2);
            chk("bounce_hold", 32'(button[2]), 32'h1);
        end
        button_raw[2] = 1'b0;
        wait_btn(4'b0100, 4'b0000, n, pr, rl);
        chk("bounce_latency", 32'(n), 32'd6);
        chk("bounce_press", 32'(pr), 32'b0100);
        button_raw[2] = 1'b1;
        step(10);

        // Three-cycle glitch on switch 5
        switch_raw[5] = 1'b1;
        step(3);
        switch_raw[5] = 1'b0;
        step(8);
        chk("glitch_level", 32'(switch[5]), 32'h0);
        chk("glitch_cnt", 32'(dut.g_switch[5].u_debounce.cnt_q), 32'h0);

        // All buttons together
        button_raw = 4'h0;
        wait_btn(4'hF, 4'h0, n, pr, rl);
        chk("simul_latency", 32'(n), 32'd6);
        chk("simul_press", 32'(pr), 32'hF);
        step(3);
        button_raw = 4'hF;
        wait_btn(4'hF, 4'hF, n, pr, rl);
        chk("simul_release", 32'(rl), 32'hF);
        step(6);

        // Reset during a held press on button 3
        button_raw[3] = 1'b0;
        step(4);
        chk("midrst_before", 32'(button[3]), 32'h1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        step(2);
        rst_n = 1'b1;
        wait_btn(4'b1000, 4'b0000, n, pr, rl);
        chk("midrst_latency", 32'(n), 32'd6);
        chk("midrst_press", 32'(pr), 32'b1000);
        button_raw[3] = 1'b1;
        step(10);

        // Random activity: frequent flips give glitches, occasional quiet
        // stretches let levels settle
        for (int c = 0; c < 600; c++) begin
            if (c % 40 < 30) begin
                for (int b = 0; b < NUM_SWITCHES; b++)
                    if ($urandom_range(4, 0) == 0) switch_raw[b] = ~switch_raw[b];
                for (int b = 0; b < NUM_BUTTONS; b++)
                    if ($urandom_range(4, 0) == 0) button_raw[b] = ~button_raw[b];
            end
            step(1);
        end

        switch_raw = '0;
        button_raw = '1;
        step(12);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
